// File: rtl/hrm_pkg.sv
// Shared package: default instruction width, queue depth limits, and the
// per-cycle queue operation type.
package hrm_pkg;

  localparam int unsigned HRM_WIDTH_DEF = 8;
  localparam int unsigned HRM_DEPTH_DEF = 4;
  localparam int unsigned HRM_DEPTH_MIN = 2;
  localparam int unsigned HRM_DEPTH_MAX = 16;

  // What the queue control does at the next rising edge
  typedef enum logic [2:0] {
    Q_HOLD,   // no change
    Q_PUSH,   // store nIR at the tail
    Q_POP,    // drop the head
    Q_SWAP,   // drop the head and store nIR, count unchanged
    Q_CLEAR   // reset or flush: discard everything
  } q_op_e;

endpackage

// File: rtl/ir_queue_mem.sv
// Instruction queue storage: DEPTH x WIDTH array.
// One synchronous write port and one asynchronous read port.
// The contents are never reset; validity is tracked by the controller.
module ir_queue_mem
  import hrm_pkg::*;
#(
  parameter int unsigned WIDTH = HRM_WIDTH_DEF,
  parameter int unsigned DEPTH = HRM_DEPTH_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write the incoming word at the tail slot
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ir_queue.sv
// Instruction FIFO with flush, pointer/count control around ir_queue_mem.
// Optional macro IR_QUEUE_BYPASS_EN: when the queue is empty, a pushed word
// appears on rIR in the same cycle (and can be consumed without storing it).
// Without the macro there is no combinational path from nIR/wIR to rIR/valid.
module ir_queue
  import hrm_pkg::*;
#(
  parameter int unsigned WIDTH = HRM_WIDTH_DEF,
  parameter int unsigned DEPTH = HRM_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           nIR,
  input  logic                       wIR,
  input  logic                       rd,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rIR,
  output logic                       valid,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_rdata;
  logic             w_stored;
  logic             w_byp;
  logic             w_pop;
  logic             w_push;
  q_op_e            w_op;

  assign w_stored = (r_count != '0);
  assign full     = (r_count == CW'(DEPTH));
  assign count    = r_count;

`ifdef IR_QUEUE_BYPASS_EN
  assign w_byp = (r_count == '0) && wIR && !flush;
`else
  assign w_byp = 1'b0;
`endif

  // A pop only touches storage when an entry is stored. A bypassed word
  // consumed in the same cycle is neither stored nor popped.
  assign w_pop  = rd && w_stored;
  assign w_push = wIR && (!full || w_pop) && !(w_byp && rd);

  // Head word and valid flag, forced to zero when nothing is presented
  always_comb begin
    valid = w_stored;
    rIR   = w_stored ? w_rdata : '0;
    if (w_byp) begin
      valid = 1'b1;
      rIR   = nIR;
    end
  end

  // Select the operation for the next edge: rst > flush > push/pop
  always_comb begin
    w_op = Q_HOLD;
    if (rst || flush)      w_op = Q_CLEAR;
    else if (w_push && w_pop) w_op = Q_SWAP;
    else if (w_push)       w_op = Q_PUSH;
    else if (w_pop)        w_op = Q_POP;
  end

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk) begin
    case (w_op)
      Q_CLEAR: begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end
      Q_PUSH: begin
        r_wptr  <= r_wptr + PW'(1);
        r_count <= r_count + CW'(1);
      end
      Q_POP: begin
        r_rptr  <= r_rptr + PW'(1);
        r_count <= r_count - CW'(1);
      end
      Q_SWAP: begin
        r_wptr  <= r_wptr + PW'(1);
        r_rptr  <= r_rptr + PW'(1);
      end
      default: ;
    endcase
  end

  ir_queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    ((w_op == Q_PUSH) || (w_op == Q_SWAP)),
    .i_waddr (r_wptr),
    .i_wdata (nIR),
    .i_raddr (r_rptr),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_ir_queue.sv
// Testbench for ir_queue (WIDTH=8, DEPTH=4): directed vector table, wrap and
// bypass sequences, then random traffic against a queue-based model.
module tb_ir_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] nIR = '0;
  logic       wIR = 1'b0;
  logic       rd = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] rIR;
  logic       valid;
  logic       full;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ir_queue #(.WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .nIR   (nIR),
    .wIR   (wIR),
    .rd    (rd),
    .flush (flush),
    .rIR   (rIR),
    .valid (valid),
    .full  (full),
    .count (count)
  );

  typedef struct {
    logic       r, f, w, d;
    logic [7:0] n;
    logic [2:0] c;
    logic       v, fl;
    logic [7:0] ir;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] c, input logic v,
                             input logic fl, input logic [7:0] ir);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".valid"}, 32'(valid), 32'(v));
    check({tag, ".full"},  32'(full),  32'(fl));
    check({tag, ".rIR"},   32'(rIR),   32'(ir));
  endtask

  // Drive one cycle of inputs, then release them so checks see stored state only
  task automatic step(input logic r, input logic f, input logic w, input logic d,
                      input logic [7:0] n);
    @(negedge clk);
    rst = r; flush = f; wIR = w; rd = d; nIR = n;
    @(posedge clk);
    #1;
    rst = 0; flush = 0; wIR = 0; rd = 0;
    #1;
  endtask

  vec_t vt[$];
  logic [7:0] mq[$];

  initial begin
    //        r  f  w  d  nIR    cnt v  full rIR
    vt.push_back('{1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00}); // reset
    vt.push_back('{0, 0, 1, 0, 8'h11, 1, 1, 0, 8'h11});
    vt.push_back('{0, 0, 1, 0, 8'h22, 2, 1, 0, 8'h11});
    vt.push_back('{0, 0, 1, 0, 8'h33, 3, 1, 0, 8'h11});
    vt.push_back('{0, 0, 1, 0, 8'h44, 4, 1, 1, 8'h11}); // full
    vt.push_back('{0, 0, 1, 0, 8'h55, 4, 1, 1, 8'h11}); // dropped
    vt.push_back('{0, 0, 1, 1, 8'h55, 4, 1, 1, 8'h22}); // push+pop at full
    vt.push_back('{0, 0, 0, 1, 8'h00, 3, 1, 0, 8'h33});
    vt.push_back('{0, 0, 0, 1, 8'h00, 2, 1, 0, 8'h44});
    vt.push_back('{0, 0, 0, 1, 8'h00, 1, 1, 0, 8'h55}); // 0x55 exits last
    vt.push_back('{0, 0, 0, 1, 8'h00, 0, 0, 0, 8'h00});
    vt.push_back('{0, 0, 0, 1, 8'h00, 0, 0, 0, 8'h00}); // pop on empty
    vt.push_back('{0, 0, 1, 0, 8'h01, 1, 1, 0, 8'h01});
    vt.push_back('{0, 0, 1, 0, 8'h02, 2, 1, 0, 8'h01});
    vt.push_back('{0, 0, 1, 0, 8'h03, 3, 1, 0, 8'h01});
    vt.push_back('{0, 1, 1, 1, 8'h66, 0, 0, 0, 8'h00}); // flush beats push/pop
    vt.push_back('{0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00}); // 0x66 not stored
    vt.push_back('{0, 0, 1, 0, 8'h77, 1, 1, 0, 8'h77});
    vt.push_back('{1, 1, 1, 0, 8'h88, 0, 0, 0, 8'h00}); // rst beats all

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].r, vt[i].f, vt[i].w, vt[i].d, vt[i].n);
      check_state($sformatf("vec%0d", i), vt[i].c, vt[i].v, vt[i].fl, vt[i].ir);
    end

    // Wrap: hold count at 1 through 10 push/pop pairs
    step(0, 0, 1, 0, 8'hA0);
    check_state("wrap_seed", 1, 1, 0, 8'hA0);
    for (int i = 1; i <= 10; i++) begin
      step(0, 0, 1, 1, 8'(i));
      check_state($sformatf("wrap%0d", i), 1, 1, 0, 8'(i));
    end
    step(0, 0, 0, 1, 8'h00);
    check_state("wrap_drain", 0, 0, 0, 8'h00);

    // Bypass: push with rd on an empty queue
    @(negedge clk);
    wIR = 1; rd = 1; nIR = 8'h7E;
    #1;
`ifdef IR_QUEUE_BYPASS_EN
    check("byp_same.rIR", 32'(rIR), 32'h7E);
    check("byp_same.valid", 32'(valid), 32'd1);
`else
    check("byp_same.rIR", 32'(rIR), 32'h00);
    check("byp_same.valid", 32'(valid), 32'd0);
`endif
    @(posedge clk);
    #1;
    wIR = 0; rd = 0;
    #1;
`ifdef IR_QUEUE_BYPASS_EN
    check_state("byp_next", 0, 0, 0, 8'h00);
`else
    check_state("byp_next", 1, 1, 0, 8'h7E);
`endif
    step(0, 1, 0, 0, 8'h00);
    check_state("byp_clear", 0, 0, 0, 8'h00);

    // Random traffic against a queue model
    mq.delete();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic r, f, w, d, ev;
      logic [7:0] n, eir;
      @(negedge clk);
      r = ($urandom_range(0, 49) == 0);
      f = ($urandom_range(0, 19) == 0);
      w = ($urandom_range(0, 99) < 60);
      d = ($urandom_range(0, 99) < 45);
      n = 8'($urandom);
      rst = r; flush = f; wIR = w; rd = d; nIR = n;
      #1;
      ev  = (mq.size() > 0);
      eir = ev ? mq[0] : 8'h00;
`ifdef IR_QUEUE_BYPASS_EN
      if (mq.size() == 0 && w && !f) begin
        ev  = 1'b1;
        eir = n;
      end
`endif
      check_state($sformatf("rnd%0d", cyc), 3'(mq.size()), ev, (mq.size() == 4), eir);
      @(posedge clk);
      if (r || f) begin
        mq.delete();
      end else begin
        logic pop_ok, push_ok;
        pop_ok = d && ev;
`ifdef IR_QUEUE_BYPASS_EN
        if (mq.size() == 0 && w) begin
          if (!d) mq.push_back(n);
        end else begin
`else
        begin
`endif
          push_ok = w && (mq.size() < 4 || pop_ok);
          if (pop_ok) void'(mq.pop_front());
          if (push_ok) mq.push_back(n);
        end
      end
    end
    @(negedge clk);
    rst = 0; flush = 0; wIR = 0; rd = 0;

    // Reset after traffic: make sure something is stored first
    step(0, 0, 1, 0, 8'h5A);
    step(1, 0, 0, 0, 8'h00);
    check_state("rst_after_traffic", 0, 0, 0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ir_queue.md
IR_QUEUE -- requirements
Module: ir_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 8, instruction word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; power of 2, 2 to 16.
REQ-003 SHALL have port clk, input, 1 bit, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous, active-high reset.
REQ-005 SHALL have port nIR, input, WIDTH bits, instruction word to enqueue.
REQ-006 SHALL have port wIR, input, 1 bit, push strobe.
REQ-007 SHALL have port rd, input, 1 bit, pop strobe; consumes the head entry.
REQ-008 SHALL have port flush, input, 1 bit, discards all entries (branch/jump redirect).
REQ-009 SHALL have port rIR, output, WIDTH bits, head instruction word.
REQ-010 SHALL have port valid, output, 1 bit, rIR holds a real entry.
REQ-011 SHALL have port full, output, 1 bit, count equals DEPTH.
REQ-012 SHALL have port count, output, $clog2(DEPTH+1) bits, occupied entries.

Function
REQ-013 SHALL operate as a FIFO: entries leave rIR in push order.
REQ-014 SHALL accept a push when wIR=1 and (full=0 or rd=1 with valid=1).
REQ-015 SHALL ignore a push when full=1 and rd=0: no state change, no error flag.
REQ-016 SHALL perform a pop when rd=1 and valid=1; rd=1 with valid=0 has no effect.
REQ-017 SHALL, on simultaneous accepted push and pop, leave count unchanged and advance both pointers.
REQ-018 SHALL keep read and write pointers as $clog2(DEPTH)-bit indices that wrap from DEPTH-1 to 0.
REQ-019 SHALL drive rIR to all-zeros whenever valid=0.
REQ-020 SHALL make a pushed word visible on rIR one cycle after the push edge when the queue was empty (macro absent).
REQ-021 SHALL hold rIR stable while valid=1 and rd=0.
REQ-022 SHALL, on flush=1, set count=0, valid=0 and both pointers to 0 at the next edge, ignoring wIR and rd in that cycle.
REQ-023 SHALL give priority rst > flush > push/pop.

Reset
REQ-024 SHALL, on rst=1 at a rising edge, set count=0, pointers=0, valid=0, full=0, rIR=0.
REQ-025 SHALL treat reset mid-operation identically, discarding all stored entries; storage contents need not be cleared.

Configuration
REQ-026 SHALL support macro IR_QUEUE_BYPASS_EN.
REQ-027 SHALL, with IR_QUEUE_BYPASS_EN defined, drive rIR=nIR and valid=1 combinationally when count=0, wIR=1 and flush=0; a same-cycle rd consumes the word without storing it, otherwise it is stored as head.
REQ-028 SHALL, without IR_QUEUE_BYPASS_EN, have no combinational path from nIR/wIR to rIR/valid.

Structure
REQ-029 SHALL take default WIDTH and the DEPTH-range constants from the shared package hrm_pkg.
REQ-030 SHALL place storage in sub-module ir_queue_mem (DEPTH x WIDTH, one synchronous write port, asynchronous read), with pointer/count control in ir_queue.

Verification
REQ-031 Reset: rst=1 one cycle after random traffic -> count=0, valid=0, full=0, rIR=0x00 next cycle.
REQ-032 Order: push 0x11,0x22,0x33,0x44 (DEPTH=4) -> full=1, count=4; four pops -> rIR 0x11,0x22,0x33,0x44 in turn, then valid=0.
REQ-033 Full: full queue, push 0x55 with rd=0 -> dropped, count=4; push 0x55 with rd=1 -> head advances, count=4, 0x55 exits last.
REQ-034 Wrap: 10 push/pop pairs of 0x01..0x0A at count=1 -> pointers wrap, output order preserved, count stays 1.
REQ-035 Flush: count=3, flush=1 with wIR=1 nIR=0x66 -> count=0, valid=0 next cycle, 0x66 never appears.
REQ-036 Bypass: empty queue, wIR=1 nIR=0x7E rd=1 -> with IR_QUEUE_BYPASS_EN rIR=0x7E same cycle and count stays 0; without it rd ignored, rIR=0x7E next cycle, count=1.
